axi4_reg_slice: RTL

Parametrised AXI4 register slice covering all five channels (AW, W, B, AR, R), inserted between an upstream AXI4 master and a downstream AXI4 slave to break timing paths. Each channel independently selects one of four buffering modes: bypass, forward-registered, half-rate, or full-throughput skid. The slice is protocol-transparent. It never reorders, drops, duplicates or alters beats.

---
 rtl/axi4_reg_slice.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: five independent channel slices (AW, W, B, AR, R), each
// selecting bypass, forward-registered, full-throughput skid or half-rate buffering.
`timescale 1ns/1ps

module axi4_reg_slice_chan #(
  parameter int unsigned MODE  = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  localparam int unsigned MODE_BYPASS = 0;
  localparam int unsigned MODE_FWD    = 1;
  localparam int unsigned MODE_FULL   = 2;
  localparam int unsigned MODE_HALF   = 3;

  if (MODE == MODE_BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = aclk ^ areset_n;
    assign out_valid_o    = in_valid_i;
    assign out_data_o     = in_data_i;
    assign in_ready_o     = out_ready_i;
  end else if (MODE == MODE_FWD) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             push;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign push       = in_valid_i & in_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
      if (!areset_n)        valid_q <= 1'b0;
      else if (push)        valid_q <= 1'b1;
      else if (out_ready_i) valid_q <= 1'b0;
    end

    // NOTE: payload registers are not reset; the valid qualifier alone makes their content meaningful.
    always_ff @(posedge aclk) begin
      if (push) data_q <= in_data_i;
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
  end else if (MODE == MODE_HALF) begin : g_half
    logic             full_q;
    logic             ready_q;
    logic [WIDTH-1:0] data_q;
    logic             push;
    logic             pop;

    assign push = in_valid_i & ready_q;
    assign pop  = full_q & out_ready_i;

    always_ff @(posedge aclk) begin
      if (!areset_n) begin
        full_q  <= 1'b0;
        ready_q <= 1'b0;
      end else if (push) begin
        full_q  <= 1'b1;
        ready_q <= 1'b0;
      end else if (pop) begin
        full_q  <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        ready_q <= ~full_q;
      end
    end

    always_ff @(posedge aclk) begin
      if (push) data_q <= in_data_i;
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
  end else if (MODE == MODE_FULL) begin : g_full
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_e;

    state_e           state_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign push = in_valid_i & ready_q;
    assign pop  = valid_q & out_ready_i;

    // ready_q is held low through reset and rises on the first edge out of it.
    always_ff @(posedge aclk) begin
      if (!areset_n) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            ready_q <= 1'b1;
            if (push) begin
              state_q <= ST_BUSY;
              valid_q <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (push && !pop) begin
              state_q <= ST_FULL;
              ready_q <= 1'b0;
            end else if (pop && !push) begin
              state_q <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end
          ST_FULL: begin
            if (pop) begin
              state_q <= ST_BUSY;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge aclk) begin
      unique case (state_q)
        ST_EMPTY: if (push) main_q <= in_data_i;
        ST_BUSY: begin
          if (push && pop) main_q <= in_data_i;
          else if (push)   skid_q <= in_data_i;
        end
        ST_FULL:  if (pop) main_q <= skid_q;
        default: ;
      endcase
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
  end else begin : g_bad_mode
    $error("axi4_reg_slice_chan: MODE %0d is not in 0..3", MODE);
  end
endmodule

module axi4_reg_slice #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned AW_MODE    = 2,
  parameter int unsigned AR_MODE    = 2,
  parameter int unsigned W_MODE     = 2,
  parameter int unsigned B_MODE     = 2,
  parameter int unsigned R_MODE     = 2
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  // AW
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic [3:0]            s_awcache,
  input  logic [2:0]            s_awprot,
  input  logic [3:0]            s_awqos,
  input  logic [3:0]            s_awregion,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ID_WIDTH-1:0]   m_awid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic [3:0]            m_awcache,
  output logic [2:0]            m_awprot,
  output logic [3:0]            m_awqos,
  output logic [3:0]            m_awregion,
  // W
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wlast,
  // B
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [ID_WIDTH-1:0]   m_bid,
  input  logic [1:0]            m_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  // AR
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic [3:0]            s_arcache,
  input  logic [2:0]            s_arprot,
  input  logic [3:0]            s_arqos,
  input  logic [3:0]            s_arregion,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic [3:0]            m_arqos,
  output logic [3:0]            m_arregion,
  // R
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast
);
  localparam int unsigned AX_W = ID_WIDTH + ADDR_WIDTH + 28;
  localparam int unsigned W_W  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int unsigned B_W  = ID_WIDTH + 2;
  localparam int unsigned R_W  = ID_WIDTH + DATA_WIDTH + 3;

  logic [AX_W-1:0] m_aw_data, m_ar_data;
  logic [W_W-1:0]  m_w_data;
  logic [B_W-1:0]  s_b_data;
  logic [R_W-1:0]  s_r_data;

  axi4_reg_slice_chan #(.MODE(AW_MODE), .WIDTH(AX_W)) u_aw (
    .aclk, .areset_n,
    .in_valid_i (s_awvalid), .in_ready_o (s_awready),
    .in_data_i  ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
                  s_awcache, s_awprot, s_awqos, s_awregion}),
    .out_valid_o(m_awvalid), .out_ready_i(m_awready), .out_data_o(m_aw_data)
  );
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
          m_awcache, m_awprot, m_awqos, m_awregion} = m_aw_data;

  axi4_reg_slice_chan #(.MODE(W_MODE), .WIDTH(W_W)) u_w (
    .aclk, .areset_n,
    .in_valid_i (s_wvalid), .in_ready_o (s_wready),
    .in_data_i  ({s_wdata, s_wstrb, s_wlast}),
    .out_valid_o(m_wvalid), .out_ready_i(m_wready), .out_data_o(m_w_data)
  );
  assign {m_wdata, m_wstrb, m_wlast} = m_w_data;

  axi4_reg_slice_chan #(.MODE(B_MODE), .WIDTH(B_W)) u_b (
    .aclk, .areset_n,
    .in_valid_i (m_bvalid), .in_ready_o (m_bready),
    .in_data_i  ({m_bid, m_bresp}),
    .out_valid_o(s_bvalid), .out_ready_i(s_bready), .out_data_o(s_b_data)
  );
  assign {s_bid, s_bresp} = s_b_data;

  axi4_reg_slice_chan #(.MODE(AR_MODE), .WIDTH(AX_W)) u_ar (
    .aclk, .areset_n,
    .in_valid_i (s_arvalid), .in_ready_o (s_arready),
    .in_data_i  ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
                  s_arcache, s_arprot, s_arqos, s_arregion}),
    .out_valid_o(m_arvalid), .out_ready_i(m_arready), .out_data_o(m_ar_data)
  );
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
          m_arcache, m_arprot, m_arqos, m_arregion} = m_ar_data;

  axi4_reg_slice_chan #(.MODE(R_MODE), .WIDTH(R_W)) u_r (
    .aclk, .areset_n,
    .in_valid_i (m_rvalid), .in_ready_o (m_rready),
    .in_data_i  ({m_rid, m_rdata, m_rresp, m_rlast}),
    .out_valid_o(s_rvalid), .out_ready_i(s_rready), .out_data_o(s_r_data)
  );
  assign {s_rid, s_rdata, s_rresp, s_rlast} = s_r_data;
endmodule
